// File: rtl/apple1_arb_pkg.sv
`default_nettype none
// ============================================================================
// apple1_arb_pkg : shared defaults, phase width helper and arbiter FSM states
// Rev 1.0
// ============================================================================
package apple1_arb_pkg;

  localparam int ADDR_W_DEFAULT  = 13;
  localparam int CPU_DIV_DEFAULT = 25;

  function automatic int phase_width(input int cpu_div);
    return (cpu_div > 2) ? $clog2(cpu_div) : 1;
  endfunction

  typedef enum logic [0:0] {
    ST_UNSYNC = 1'b0,
    ST_RUN    = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/clken_phase_tracker.sv
`default_nettype none
// ============================================================================
// clken_phase_tracker : follows the cpu_clken cadence and marks the CPU slot
// Rev 1.0
// ============================================================================
module clken_phase_tracker
  import apple1_arb_pkg::*;
#(
  parameter int CPU_DIV = CPU_DIV_DEFAULT,
  parameter int PHASE_W = phase_width(CPU_DIV)
) (
  input  logic               clk25,
  input  logic               rst,
  input  logic               cpu_clken,
  output logic [PHASE_W-1:0] phase,
  output logic               synced,
  output logic               cpu_slot,
  output logic               sync_err
);

  localparam logic [PHASE_W-1:0] C_PH_LAST = PHASE_W'(CPU_DIV - 1);
  localparam logic [PHASE_W-1:0] C_PH_CPU  = PHASE_W'(CPU_DIV - 2);

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [PHASE_W-1:0] r_phase;
  logic               r_sync_err;
  logic               w_off_cadence;

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      r_state <= ST_UNSYNC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_off_cadence = 1'b0;
    case (r_state)
      ST_UNSYNC: begin
        if (cpu_clken) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // An early enable resyncs the counter but keeps arbitrating.
        w_off_cadence = cpu_clken && (r_phase != C_PH_LAST);
      end
      default: begin
        w_state_nxt = ST_UNSYNC;
      end
    endcase
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      r_phase    <= '0;
      r_sync_err <= 1'b0;
    end else begin
      if (cpu_clken) begin
        r_phase <= '0;
      end else if (r_phase != C_PH_LAST) begin
        r_phase <= r_phase + PHASE_W'(1);
      end
      if (w_off_cadence) begin
        r_sync_err <= 1'b1;
      end
    end
  end

  assign phase    = r_phase;
  assign synced   = (r_state == ST_RUN);
  assign cpu_slot = (r_state == ST_UNSYNC) || cpu_clken || (r_phase >= C_PH_CPU);
  assign sync_err = r_sync_err;

endmodule
`default_nettype wire

// File: rtl/ram_dma_arbiter.sv
`default_nettype none
// ============================================================================
// ram_dma_arbiter : shares the 8 KB main RAM between the 6502 and a DMA port
// Rev 1.0
// ============================================================================
module ram_dma_arbiter
  import apple1_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int CPU_DIV = CPU_DIV_DEFAULT
) (
  input  logic              clk25,
  input  logic              rst,
  input  logic              cpu_clken,
  input  logic [ADDR_W-1:0] cpu_ab,
  input  logic              cpu_ram_cs,
  input  logic              cpu_we,
  input  logic [7:0]        cpu_dbo,
  output logic [7:0]        cpu_ram_dout,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [7:0]        dma_din,
  output logic              dma_ack,
  output logic              dma_rvalid,
  output logic [7:0]        dma_rdata,
  output logic              sync_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout
);

  localparam int PHASE_W = phase_width(CPU_DIV);

  logic [PHASE_W-1:0] w_unused_phase;
  logic               w_synced;
  logic               w_cpu_slot;
  logic               w_dma_go;
  logic               r_rd_pend;
  logic               r_rvalid;
  logic [7:0]         r_rdata;

  clken_phase_tracker #(
    .CPU_DIV (CPU_DIV),
    .PHASE_W (PHASE_W)
  ) u_tracker (
    .clk25     (clk25),
    .rst       (rst),
    .cpu_clken (cpu_clken),
    .phase     (w_unused_phase),
    .synced    (w_synced),
    .cpu_slot  (w_cpu_slot),
    .sync_err  (sync_err)
  );

  assign w_dma_go = dma_req & w_synced & ~w_cpu_slot;

  // The CPU address is the idle default so the CPU read mux always sees it.
  always_comb begin
    ram_addr = cpu_ab;
    ram_din  = cpu_dbo;
    ram_we   = 1'b0;
    dma_ack  = 1'b0;
    if (w_dma_go) begin
      ram_addr = dma_addr;
      ram_din  = dma_din;
      ram_we   = dma_we;
      dma_ack  = 1'b1;
    end else if (w_cpu_slot) begin
      ram_we = cpu_we & cpu_ram_cs & cpu_clken & ~rst;
    end
  end

  // Read return: RAM data appears one cycle after issue and is latched then,
  // so the address moving back to the CPU does not disturb it.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      r_rd_pend <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= 8'h00;
    end else begin
      r_rd_pend <= w_dma_go & ~dma_we;
      r_rvalid  <= r_rd_pend;
      if (r_rd_pend) begin
        r_rdata <= ram_dout;
      end
    end
  end

  assign dma_rvalid   = r_rvalid;
  assign dma_rdata    = r_rdata;
  assign cpu_ram_dout = ram_dout;

endmodule
`default_nettype wire
